// File: rtl/pwm_demod.sv
// PWM receive decoder: measures the high time of each PWM frame and reports it as an
// 8-bit sample, with frame-length checking, zero-duty detection and lock tracking.
module pwm_demod #(
  parameter int PERIOD      = 256,
  parameter int TOL         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       pwm_i,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       locked,
  output logic       frame_err
);
  localparam int CW = $clog2(PERIOD + TOL + 1);
  localparam int GW = $clog2(LOCK_FRAMES + 1);

  localparam logic [CW-1:0] LEN_MAX   = CW'(PERIOD + TOL);
  localparam logic [CW-1:0] LEN_MIN   = CW'(PERIOD - TOL);
  localparam logic [CW-1:0] ZERO_WRAP = CW'(PERIOD - 1);
  localparam logic [CW-1:0] SAT_8     = CW'(255);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [CW-1:0] TOL_C     = CW'(TOL);
  localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_FRAMES);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_HIGH   = 2'd1;
  localparam logic [1:0] S_LOW    = 2'd2;
  localparam logic [1:0] S_ZERO   = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line_prev_q;
  logic                   line, rise, fall;

  assign line = sync_q[SYNC_STAGES-1];
  assign rise = line & ~line_prev_q;
  assign fall = ~line & line_prev_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q      <= '0;
      line_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      line_prev_q <= line;
    end
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d, zcnt_q, zcnt_d;
  logic [GW-1:0] good_q, good_d;
  logic [7:0]    sample_q, sample_d;
  logic          valid_q, valid_d, err_q, err_d, locked_q, locked_d;
  logic          accept, reject, start;

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    zcnt_d   = zcnt_q;
    good_d   = good_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;
    accept   = 1'b0;
    reject   = 1'b0;
    start    = 1'b0;

    case (state_q)
      S_SEARCH: start = rise;
      S_HIGH: begin
        if (fall) begin
          state_d = S_LOW;
          pcnt_d  = (pcnt_q >= LEN_MAX) ? LEN_MAX : pcnt_q + ONE_C;
        end else if (pcnt_q >= LEN_MAX) begin
          reject  = 1'b1;
          state_d = S_SEARCH;
        end else begin
          pcnt_d = pcnt_q + ONE_C;
          hcnt_d = hcnt_q + ONE_C;
        end
      end
      S_LOW: begin
        // The rise that closes a frame also opens the next one.
        if (rise) begin
          start = 1'b1;
          if (pcnt_q >= LEN_MIN && pcnt_q <= LEN_MAX) accept = 1'b1;
          else                                        reject = 1'b1;
        end else if (pcnt_q >= LEN_MAX) begin
          accept  = 1'b1;
          state_d = S_ZERO;
          zcnt_d  = TOL_C;
        end else begin
          pcnt_d = pcnt_q + ONE_C;
        end
      end
      default: begin
        // Line parked low: emit a zero sample once per nominal frame.
        if (rise) begin
          start = 1'b1;
        end else if (zcnt_q == ZERO_WRAP) begin
          sample_d = 8'h00;
          valid_d  = 1'b1;
          zcnt_d   = '0;
        end else begin
          zcnt_d = zcnt_q + ONE_C;
        end
      end
    endcase

    if (start) begin
      state_d = S_HIGH;
      hcnt_d  = ONE_C;
      pcnt_d  = ONE_C;
    end
    if (accept) begin
      sample_d = (hcnt_q > SAT_8) ? 8'hFF : hcnt_q[7:0];
      valid_d  = 1'b1;
      if (good_q < GOOD_MAX) good_d = good_q + 1'b1;
    end
    if (reject) begin
      err_d  = 1'b1;
      good_d = '0;
    end
    if (reject)                  locked_d = 1'b0;
    else if (good_d >= GOOD_MAX) locked_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_SEARCH;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      zcnt_q   <= '0;
      good_q   <= '0;
      sample_q <= 8'h00;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      zcnt_q   <= zcnt_d;
      good_q   <= good_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign locked       = locked_q;
endmodule

// File: tb/tb_pwm_demod.sv
// Bench for pwm_demod: builds a pin waveform from directed and random frames, predicts
// every output from rise/fall times with frame-level arithmetic, and checks each clock.
module tb_pwm_demod;
  localparam int P = 256;
  localparam int T = 2;

  logic       clk, nrst, pwm_i;
  logic [7:0] sample;
  logic       sample_valid, locked, frame_err;

  pwm_demod #(.PERIOD(P), .TOL(T), .SYNC_STAGES(2), .LOCK_FRAMES(2)) dut (
    .clk(clk), .nrst(nrst), .pwm_i(pwm_i), .sample(sample),
    .sample_valid(sample_valid), .locked(locked), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit pin_q[$];
  bit rst_q[$];
  int ev_kind[];   // 0 none, 1 frame sample, 2 frame error, 3 zero-duty sample
  int ev_val[];
  int x_smp[];
  int x_lk[];
  int n_slots;
  int slot;
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s slot=%0d got=%0d expected=%0d", tag, slot, obs, exp);
    end
  endtask

  task automatic add_seg(input bit v, input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      pin_q.push_back(v);
      rst_q.push_back(r);
    end
  endtask

  task automatic add_frame(input int h, input int len);
    add_seg(1'b1, h, 1'b0);
    add_seg(1'b0, len - h, 1'b0);
  endtask

  // Output of a decision taken while the synced line shows slot d is visible at slot d+3.
  task automatic post(input int d, input int kind, input int val, input int hz);
    if (d + 3 < hz && d + 3 < n_slots) begin
      ev_kind[d+3] = kind;
      ev_val[d+3]  = val;
    end
  endtask

  task automatic build_model();
    bit e[];
    int good, smp, lk;
    n_slots = pin_q.size();
    e       = new[n_slots];
    ev_kind = new[n_slots];
    ev_val  = new[n_slots];
    x_smp   = new[n_slots];
    x_lk    = new[n_slots];
    for (int n = 0; n < n_slots; n++) e[n] = rst_q[n] ? 1'b0 : pin_q[n];
    for (int r = 1; r < n_slots; r++) begin
      if (e[r] && !e[r-1]) begin
        int hz, f, rn, h, len, hs;
        hz = n_slots;
        for (int k = r + 1; k < n_slots; k++) if (rst_q[k]) begin hz = k; break; end
        f = n_slots;
        for (int k = r + 1; k < n_slots; k++) if (!e[k]) begin f = k; break; end
        rn = n_slots + 4 * P;
        for (int k = f + 1; k < n_slots; k++) if (e[k] && !e[k-1]) begin rn = k; break; end
        h   = f - r;
        len = rn - r;
        hs  = (h > 255) ? 255 : h;
        if (h > P + T) post(r + P + T, 2, 0, hz);
        else if (len <= P + T) begin
          if (len >= P - T) post(rn, 1, hs, hz);
          else              post(rn, 2, 0, hz);
        end else begin
          post(r + P + T, 1, hs, hz);
          for (int d = r + 2 * P; d < rn && d < n_slots; d += P) post(d, 3, 0, hz);
        end
      end
    end
    good = 0; smp = 0; lk = 0;
    for (int n = 0; n < n_slots; n++) begin
      if (rst_q[n]) begin good = 0; smp = 0; lk = 0; end
      else if (ev_kind[n] == 1) begin
        smp  = ev_val[n];
        good = (good < 2) ? good + 1 : 2;
        if (good >= 2) lk = 1;
      end else if (ev_kind[n] == 2) begin
        good = 0; lk = 0;
      end else if (ev_kind[n] == 3) smp = 0;
      x_smp[n] = smp;
      x_lk[n]  = lk;
    end
  endtask

  initial begin
    nrst  = 1'b0;
    pwm_i = 1'b0;
    add_seg(1'b0, 4, 1'b1);
    add_seg(1'b0, 20, 1'b0);
    repeat (3) add_frame(8'h80, P);
    repeat (3) add_frame(8'hFF, P);
    add_frame(8'h40, P + 1000);
    repeat (2) add_frame(8'h60, P);
    repeat (3) add_frame(8'h30, 250);
    repeat (3) add_frame(8'h50, P);
    add_seg(1'b1, 300, 1'b0);
    add_seg(1'b0, 100, 1'b0);
    repeat (3) add_frame(8'h70, P);
    repeat (2) add_frame(8'h90, P);
    add_seg(1'b1, 50, 1'b0);
    add_seg(1'b1, 5, 1'b1);
    add_seg(1'b1, 8'h90 - 55, 1'b0);
    add_seg(1'b0, P - 8'h90, 1'b0);
    repeat (3) add_frame(8'h90, P);
    for (int i = 0; i < 30; i++) begin
      int kind, h, len;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        len = $urandom_range(P - T, P + T);
        h   = $urandom_range(1, 255);
      end else if (kind == 6) begin
        len = $urandom_range(180, P - T - 1);
        h   = $urandom_range(1, 170);
      end else if (kind == 7) begin
        len = $urandom_range(P + T + 1, 3 * P + 20);
        h   = $urandom_range(1, 255);
      end else if (kind == 8) begin
        len = 0;
        h   = 0;
        add_seg(1'b1, $urandom_range(260, 400), 1'b0);
        add_seg(1'b0, $urandom_range(1, 100), 1'b0);
      end else begin
        len = ($urandom_range(0, 1) != 0) ? P - T : P + T;
        h   = ($urandom_range(0, 1) != 0) ? 255 : 1;
      end
      if (kind != 8) begin
        if (h > len - 1) h = len - 1;
        add_frame(h, len);
      end
    end
    repeat (2) add_frame(8'h33, P);
    add_seg(1'b0, 700, 1'b0);
    build_model();

    for (int n = 0; n < n_slots; n++) begin
      @(negedge clk);
      pwm_i = pin_q[n];
      nrst  = ~rst_q[n];
      #1;
      slot = n;
      check_eq("sample_valid", int'(sample_valid), int'(ev_kind[n] == 1 || ev_kind[n] == 3));
      check_eq("frame_err", int'(frame_err), int'(ev_kind[n] == 2));
      check_eq("sample", int'(sample), x_smp[n]);
      check_eq("locked", int'(locked), x_lk[n]);
      if (sample_valid || frame_err)
        $display("slot %0d: valid=%0d err=%0d sample=0x%02h locked=%0d",
                 n, sample_valid, frame_err, sample, locked);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
